// File: rtl/obstacle_field_gen_if.sv
// obstacle_field_gen_if: game-side control inputs and obstacle-slot outputs of the obstacle generator.
// Ports: master drives tick/halt/rng/speed and reads the slot outputs; slave is the generator.
interface obstacle_field_gen_if #(
  parameter int NUM_OBS = 2,
  parameter int POS_W   = 9,
  parameter int TYPE_W  = 3
);
  logic                      tick;
  logic                      halt;
  logic [7:0]                rng;
  logic [1:0]                speed;
  logic [NUM_OBS*POS_W-1:0]  obs_pos;
  logic [NUM_OBS*TYPE_W-1:0] obs_type;
  logic [NUM_OBS-1:0]        obs_valid;
  logic                      spawn_pulse;
  logic                      score_pulse;
  logic [3:0]                step_out;
  modport master (output tick, halt, rng, speed,
                  input obs_pos, obs_type, obs_valid, spawn_pulse, score_pulse, step_out);
  modport slave  (input tick, halt, rng, speed,
                  output obs_pos, obs_type, obs_valid, spawn_pulse, score_pulse, step_out);
endinterface

// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen: scrolls, retires and spawns NUM_OBS obstacle slots on each game tick.
// Ports: clk, rst (sync, active-high); bus (slave): tick/halt/rng/speed in,
// obs_pos/obs_type/obs_valid/spawn_pulse/score_pulse/step_out out (all registered).
// Option macro OBSTACLES_SPEEDUP_EN adds a retirement-driven speed bonus (0..3).
module obstacle_field_gen #(
  parameter int NUM_OBS       = 2,
  parameter int POS_W         = 9,
  parameter int TYPE_W        = 3,
  parameter int NUM_TYPES     = 5,
  parameter int SPAWN_X       = 320,
  parameter int GEN_LINE      = 250,
  parameter int SPAWN_THRESH  = 12,
  parameter int SPEEDUP_EVERY = 8
) (
  input logic clk,
  input logic rst,
  obstacle_field_gen_if.slave bus
);
  localparam logic [POS_W-1:0]  SPAWN_P = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0]  GEN_P   = POS_W'(GEN_LINE);
  localparam logic [4:0]        THR_P   = 5'(SPAWN_THRESH);
  localparam logic [TYPE_W:0]   NT_P    = (TYPE_W+1)'(NUM_TYPES);
  logic [NUM_OBS*POS_W-1:0]  pos_q, pos_d;
  logic [NUM_OBS*TYPE_W-1:0] type_q, type_d;
  logic [NUM_OBS-1:0]        valid_q, valid_d;
  logic                      spawn_q, score_q, spawned, retire, far, adv;
  logic [3:0]                step_q, step;
  logic [POS_W-1:0]          step_w;
  logic [1:0]                bonus_q, bonus_d;
  function automatic logic [3:0] sat_step(input logic [1:0] spd, input logic [1:0] bon);
    logic [3:0] raw;
    raw = {2'b0, spd} + 4'd1 + {2'b0, bon};
    return raw > 4'd8 ? 4'd8 : raw;
  endfunction
  assign adv    = bus.tick && !bus.halt;
  assign step   = sat_step(bus.speed, bonus_q);
  assign step_w = POS_W'(step);
  always_comb begin
    pos_d   = pos_q;
    type_d  = type_q;
    valid_d = valid_q;
    retire  = 1'b0;
    far     = 1'b0;
    spawned = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (valid_q[i]) begin
        if (pos_q[i*POS_W +: POS_W] < step_w) begin
          valid_d[i]                 = 1'b0;
          pos_d[i*POS_W +: POS_W]    = '0;
          type_d[i*TYPE_W +: TYPE_W] = '0;
          retire                     = 1'b1;
        end else begin
          pos_d[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] - step_w;
          far = far | (pos_d[i*POS_W +: POS_W] > GEN_P);
        end
      end
    end
    // only slots free before this tick are candidates, so a just-retired slot waits a tick
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!far && ({1'b0, bus.rng[7:4]} < THR_P) && !valid_q[i] && !spawned) begin
        valid_d[i]                 = 1'b1;
        pos_d[i*POS_W +: POS_W]    = SPAWN_P;
        type_d[i*TYPE_W +: TYPE_W] = TYPE_W'({1'b0, bus.rng[TYPE_W-1:0]} % NT_P);
        spawned                    = 1'b1;
      end
    end
  end
`ifdef OBSTACLES_SPEEDUP_EN
  localparam int CW = $clog2(SPEEDUP_EVERY + 1);
  logic [CW-1:0] cnt_q;
  logic          wrap;
  assign wrap    = cnt_q == CW'(SPEEDUP_EVERY - 1);
  assign bonus_d = (adv && retire && wrap && bonus_q != 2'd3) ? bonus_q + 2'd1 : bonus_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bonus_q <= '0;
    end else if (adv && retire) begin
      cnt_q   <= wrap ? '0 : cnt_q + CW'(1);
      bonus_q <= bonus_d;
    end
  end
`else
  assign bonus_q = '0;
  assign bonus_d = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      type_q  <= '0;
      valid_q <= '0;
      spawn_q <= 1'b0;
      score_q <= 1'b0;
      step_q  <= sat_step(bus.speed, 2'd0);
    end else if (adv) begin
      pos_q   <= pos_d;
      type_q  <= type_d;
      valid_q <= valid_d;
      spawn_q <= spawned;
      score_q <= retire;
      step_q  <= sat_step(bus.speed, bonus_d);
    end else begin
      spawn_q <= 1'b0;
      score_q <= 1'b0;
    end
  end
  assign bus.obs_pos     = pos_q;
  assign bus.obs_type    = type_q;
  assign bus.obs_valid   = valid_q;
  assign bus.spawn_pulse = spawn_q;
  assign bus.score_pulse = score_q;
  assign bus.step_out    = step_q;
endmodule
